layer_mem_arbiter: RTL
======================

# layer_mem_arbiter

Two-requester arbiter that shares the single layer-memory port (`csel`/`crd`/`cwr`/address/data) between the convolution engine (requester A, layer-0 writes) and the max-pool engine (requester B, layer-0 reads and layer-1 writes). It sits between both engines and the top-level memory pins. It serialises transactions, registers all memory-side outputs and routes read data back to the issuing requester. Burst limiting prevents starvation.

## Interface
- `AW`, 12, address width
- `DW`, 20, data width
- `MAX_BURST`, 8, max consecutive accepted transactions by one owner while the other requester waits (range 1..255)

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_a` / `req_b`  in  1  transaction request
- `we_a` / `we_b`  in  1  1 = write, 0 = read
- `sel_a` / `sel_b`  in  3  memory select, copied to `csel`
- `addr_a` / `addr_b`  in  AW  transaction address
- `wdata_a` / `wdata_b`  in  DW  write data
- `lock_a` / `lock_b`  in  1  owner ignores `MAX_BURST` while high
- `gnt_a` / `gnt_b`  out  1  requester owns port; accept = `req_x & gnt_x`
- `rvalid_a` / `rvalid_b`  out  1  read data valid, one-cycle pulse per read
- `rdata_a` / `rdata_b`  out  DW  read data; `cdata_rd` when `rvalid_x`, else 0
- `crd`, `cwr`  out  1  memory read / write strobe
- `csel`  out  3  memory select
- `caddr_rd`, `caddr_wr`  out  AW  read / write address
- `cdata_wr`  out  DW  write data
- `cdata_rd`  in  DW  memory read data, valid the cycle after `crd`

## Operation
- FSM states: IDLE, OWN_A, OWN_B. `gnt_a` = (state==OWN_A); `gnt_b` = (state==OWN_B). Grants are registered, so they never depend combinationally on `req`.
- IDLE: no request keeps IDLE. Single request moves to that owner. Both requesting: the winner is set by the policy (see Configuration).
- OWN_x, `req_x` high: accept every cycle and increment `burst_cnt`.
- OWN_x, `req_x` low: if the other requester is requesting, go to OWN_other, else go to IDLE. No accept in this cycle.
- OWN_x, accept with `burst_cnt == MAX_BURST-1`, `lock_x` low and the other requester requesting: go to OWN_other. This accept still completes.
- `burst_cnt` clears on every state change. It saturates while `lock_x` is high.
- Accepted write: next cycle `cwr`=1, `caddr_wr`=addr, `cdata_wr`=wdata, `csel`=sel, `crd`=0.
- Accepted read: next cycle `crd`=1, `caddr_rd`=addr, `csel`=sel, `cwr`=0.
- No accept: next cycle `crd`=`cwr`=0. `csel` and the addresses hold their last values.
- Read routing: a 2-stage tag pipeline (valid, owner) tracks in-flight reads. Stage 2 drives `rvalid_owner`. `rdata` is combinational from `cdata_rd`, gated by `rvalid`.
- `last_served` register (A/B) updates on each accept.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - `last_served`=B, so A wins the first tie
  - `burst_cnt`=0
  - tag pipeline empty
- Request to grant: `req` rises in cycle T while IDLE, so `gnt` is high in T+1. Earliest accept is T+1.
- Accept in cycle T: memory strobe in T+1, read data and `rvalid_x` in T+2. Read latency is 2 cycles, fully pipelined (1 transaction/cycle).
- Ownership switch: one bubble when the owner drops `req`; zero bubble on burst-limit handover.
- Write followed by read of the same address from the other requester: ordering is preserved because the port is strictly serial.
- `reset` asserted mid-operation: everything clears immediately. In-flight reads are discarded and produce no `rvalid`.
- `MAX_BURST`=1: the port alternates every accept while both requesters are active and neither is locked.

## Configuration
- `LAYER_MEM_ARB_RR_EN` defined: IDLE tie-break is round-robin; the winner is the requester opposite `last_served`.
- `LAYER_MEM_ARB_RR_EN` undefined: IDLE tie-break is fixed priority, A always wins. Burst limiting still applies.

## Test plan
- Reset → all outputs 0. A write of addr 0x005, data 0x01234, sel 001 appears on the memory pins exactly 2 cycles after `req_a` rises: `cwr`=1, `caddr_wr`=0x005, `cdata_wr`=0x01234, `csel`=001.
- B reads 0x040 with memory returning 0x0ABCD → `rvalid_b` pulses once, exactly 2 cycles after the accept, with `rdata_b`=0x0ABCD. `rvalid_a` stays 0.
- Both requesters hold `req` continuously, no lock, `MAX_BURST`=8 → ownership alternates as 8 A accepts, then 8 B accepts, then repeats, with no bubble cycles.
- As above with `lock_a`=1 → A keeps the grant for 20+ accepts. Once `lock_a` drops with `burst_cnt` saturated, A's next accept hands over to B.
- Simultaneous `req_a`/`req_b` in IDLE, repeated 4 times with each request dropped after 1 accept → grant order A,B,A,B with RR_EN defined; A,A,A,A without.
- Back-to-back reads by A to 0x000..0x003, then `reset` asserted one cycle after the last accept → only the reads whose `rvalid` cycle precedes reset complete. After reset release, state is IDLE and no stale `rvalid` appears.

Source files
------------

// File: rtl/layer_mem_arbiter.sv
// layer_mem_arbiter
//   Shares the single layer-memory port between the convolution engine
//   (requester A) and the max-pool engine (requester B). Transactions are
//   serialised, all memory-side outputs are registered, and read data is
//   routed back to the requester that issued the read. A per-owner burst
//   limit keeps one engine from starving the other.
//
// Build option:
//   LAYER_MEM_ARB_RR_EN  defined   -> an IDLE tie goes to the requester
//                                     opposite last_served (round-robin)
//                        undefined -> an IDLE tie always goes to A
//
// Ports:
//   clk, reset (async, active-low)
//   req_x, we_x, sel_x[2:0], addr_x[AW-1:0], wdata_x[DW-1:0], lock_x  (x = a/b)
//   gnt_x                  requester owns the port; accept = req_x & gnt_x
//   rvalid_x, rdata_x      read return, two cycles after the accept
//   crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr   registered memory pins
//   cdata_rd               memory read data, valid the cycle after crd
module layer_mem_arbiter #(
    parameter int AW        = 12,
    parameter int DW        = 20,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [2:0]    sel_a,
    input  logic [2:0]    sel_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    input  logic          lock_a,
    input  logic          lock_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          crd,
    output logic          cwr,
    output logic [2:0]    csel,
    output logic [AW-1:0] caddr_rd,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    input  logic [DW-1:0] cdata_rd
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    // burst_cnt stops at this value; reaching it arms the handover
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t        state_reg;
    logic          last_served_reg;   // 0 = A, 1 = B
    logic [7:0]    burst_cnt_reg;
    logic          tag1_valid_reg;
    logic          tag1_owner_reg;    // 0 = A, 1 = B
    logic          tag2_valid_reg;
    logic          tag2_owner_reg;

    logic          accept_a;
    logic          accept_b;
    logic          accept;
    logic          acc_we;
    logic [2:0]    acc_sel;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          tie_to_a;

    assign gnt_a    = (state_reg == OWN_A);
    assign gnt_b    = (state_reg == OWN_B);
    assign accept_a = req_a & gnt_a;
    assign accept_b = req_b & gnt_b;
    assign accept   = accept_a | accept_b;

    // Only one requester can own the port, so a simple mux on accept_b suffices
    assign acc_we    = accept_b ? we_b    : we_a;
    assign acc_sel   = accept_b ? sel_b   : sel_a;
    assign acc_addr  = accept_b ? addr_b  : addr_a;
    assign acc_wdata = accept_b ? wdata_b : wdata_a;

`ifdef LAYER_MEM_ARB_RR_EN
    // B served last -> A wins the tie, and vice versa
    assign tie_to_a = last_served_reg;
`else
    assign tie_to_a = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            last_served_reg <= 1'b1;
            burst_cnt_reg   <= '0;
            tag1_valid_reg  <= 1'b0;
            tag1_owner_reg  <= 1'b0;
            tag2_valid_reg  <= 1'b0;
            tag2_owner_reg  <= 1'b0;
            crd             <= 1'b0;
            cwr             <= 1'b0;
            csel            <= '0;
            caddr_rd        <= '0;
            caddr_wr        <= '0;
            cdata_wr        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    burst_cnt_reg <= '0;
                    if (req_a && req_b) begin
                        state_reg <= tie_to_a ? OWN_A : OWN_B;
                    end else if (req_a) begin
                        state_reg <= OWN_A;
                    end else if (req_b) begin
                        state_reg <= OWN_B;
                    end
                end
                OWN_A: begin
                    if (!req_a) begin
                        state_reg     <= req_b ? OWN_B : IDLE;
                        burst_cnt_reg <= '0;
                    end else if (burst_cnt_reg == BURST_LAST && !lock_a && req_b) begin
                        // this accept completes, B owns the very next cycle
                        state_reg     <= OWN_B;
                        burst_cnt_reg <= '0;
                    end else if (burst_cnt_reg != BURST_LAST) begin
                        burst_cnt_reg <= burst_cnt_reg + 8'd1;
                    end
                end
                OWN_B: begin
                    if (!req_b) begin
                        state_reg     <= req_a ? OWN_A : IDLE;
                        burst_cnt_reg <= '0;
                    end else if (burst_cnt_reg == BURST_LAST && !lock_b && req_a) begin
                        state_reg     <= OWN_A;
                        burst_cnt_reg <= '0;
                    end else if (burst_cnt_reg != BURST_LAST) begin
                        burst_cnt_reg <= burst_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    burst_cnt_reg <= '0;
                end
            endcase

            if (accept) begin
                last_served_reg <= accept_b;
                csel            <= acc_sel;
                if (acc_we) begin
                    cwr      <= 1'b1;
                    crd      <= 1'b0;
                    caddr_wr <= acc_addr;
                    cdata_wr <= acc_wdata;
                end else begin
                    crd      <= 1'b1;
                    cwr      <= 1'b0;
                    caddr_rd <= acc_addr;
                end
            end else begin
                crd <= 1'b0;
                cwr <= 1'b0;
            end

            // stage 1 lines up with crd, stage 2 with the returning cdata_rd
            tag1_valid_reg <= accept & ~acc_we;
            tag1_owner_reg <= accept_b;
            tag2_valid_reg <= tag1_valid_reg;
            tag2_owner_reg <= tag1_owner_reg;
        end
    end

    // Read return routing: index 0 = A, index 1 = B
    logic [1:0]    rvalid_vec;
    logic [DW-1:0] rdata_vec [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_route
        assign rvalid_vec[gi] = tag2_valid_reg && (tag2_owner_reg == 1'(gi));
        assign rdata_vec[gi]  = rvalid_vec[gi] ? cdata_rd : '0;
    end

    assign rvalid_a = rvalid_vec[0];
    assign rvalid_b = rvalid_vec[1];
    assign rdata_a  = rdata_vec[0];
    assign rdata_b  = rdata_vec[1];

endmodule
